// File: rtl/fec_conv_pkg.sv
// fec_conv_pkg
// Shared definitions for the rate-1/2, K=7 convolutional encoder:
// constraint length, generator polynomials (171/133 octal), the block
// FSM state type and the function that forms one coded pair.
//
// Encoder state vectors are packed as st[5:0] = {s1, s2, s3, s4, s5, s6},
// so {u, st} lines up bit-for-bit with the generator masks (MSB = u).
package fec_conv_pkg;

    localparam int         K  = 7;
    localparam logic [6:0] G1 = 7'o171;
    localparam logic [6:0] G2 = 7'o133;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PRELOAD = 2'd1,
        ENCODE  = 2'd2
    } fsm_state_t;

    // Returns {X, Y} for input bit u and encoder state st.
    function automatic logic [1:0] conv_pair(input logic u, input logic [K-2:0] st);
        logic [K-1:0] r;
        r = {u, st};
        return {^(r & G1), ^(r & G2)};
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// conv_enc_core
// Six-bit shift-register state of the convolutional encoder plus the
// generator XOR taps.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset (state -> 0)
//   load         - state <= load_value (takes priority over step)
//   load_value   - packed {s1..s6} value to load
//   step         - shift u into the state (s1 <= u, s6 <= s5)
//   u            - input bit for the pair formed this cycle
//   x, y         - combinational G1/G2 outputs for u and the current state
module conv_enc_core
    import fec_conv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [K-2:0] load_value,
    input  logic         step,
    input  logic         u,
    output logic         x,
    output logic         y
);

    logic [K-2:0] st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= '0;
        end else if (load) begin
            st <= load_value;
        end else if (step) begin
            st <= {u, st[K-2:1]};
        end
    end

    assign {x, y} = conv_pair(u, st);

endmodule

// File: rtl/fec_conv_encoder.sv
// fec_conv_encoder
// Rate-1/2, K=7 (171/133 octal) convolutional encoder with a single block
// buffer. Collects BLOCK_LEN bits, spends one PRELOAD cycle, then emits the
// coded pairs under a valid/ready handshake.
//
// Build option: CONV_ENC_TAILBITE_EN
//   defined   - tail-biting: state preloaded from the last 6 buffered bits,
//               BLOCK_LEN pairs per block
//   undefined - zero-tail: state starts at 0, BLOCK_LEN+6 pairs per block,
//               the last 6 pairs use u=0
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_bit       - serial information bits
//   in_ready              - high in FILL
//   out_valid/out_ready   - coded pair handshake
//   out_x/out_y           - G1/G2 coded bits
//   out_first/out_last    - block delimiters, qualified by out_valid
module fec_conv_encoder
    import fec_conv_pkg::*;
#(
    parameter int BLOCK_LEN = 96
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    output logic out_x,
    output logic out_y,
    output logic out_first,
    output logic out_last
);

`ifdef CONV_ENC_TAILBITE_EN
    localparam int NUM_PAIRS = BLOCK_LEN;
`else
    localparam int NUM_PAIRS = BLOCK_LEN + K - 1;
`endif
    localparam int CW = $clog2(NUM_PAIRS + 1);
    localparam int IW = $clog2(BLOCK_LEN);
    localparam logic [CW-1:0] LAST_IN   = CW'(BLOCK_LEN - 1);
    localparam logic [CW-1:0] LAST_PAIR = CW'(NUM_PAIRS - 1);

    fsm_state_t           state;
    logic [CW-1:0]        cnt;
    logic [BLOCK_LEN-1:0] blk_buf;
    logic [IW-1:0]        idx;
    logic [K-2:0]         preload;
    logic [1:0]           first_pair;
    logic                 core_u;
    logic                 core_x;
    logic                 core_y;
    logic                 core_load;
    logic                 core_step;

    assign idx = cnt[IW-1:0];

`ifdef CONV_ENC_TAILBITE_EN
    assign preload = blk_buf[BLOCK_LEN-1 -: K-1];
    assign core_u  = blk_buf[idx];
`else
    assign preload = '0;
    assign core_u  = (cnt < CW'(BLOCK_LEN)) ? blk_buf[idx] : 1'b0;
`endif

    // The output pair is registered, so the core runs one pair ahead of
    // what is on out_x/out_y: pair 0 is formed directly from the preload
    // value during PRELOAD, and the core is loaded with the state that
    // follows pair 0. In ENCODE, cnt is the index of the next pair to form.
    assign first_pair = conv_pair(blk_buf[0], preload);
    assign core_load  = (state == PRELOAD);
    assign core_step  = (state == ENCODE) && out_ready && !out_last;

    conv_enc_core u_core (
        .clk        (clk),
        .reset      (reset),
        .load       (core_load),
        .load_value ({blk_buf[0], preload[K-2:1]}),
        .step       (core_step),
        .u          (core_u),
        .x          (core_x),
        .y          (core_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_x     <= 1'b0;
            out_y     <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid && in_ready) begin
                        blk_buf[idx] <= in_bit;
                        if (cnt == LAST_IN) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            state    <= PRELOAD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PRELOAD: begin
                    {out_x, out_y} <= first_pair;
                    out_valid      <= 1'b1;
                    out_first      <= 1'b1;
                    out_last       <= 1'b0;
                    cnt            <= CW'(1);
                    state          <= ENCODE;
                end
                ENCODE: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_x     <= 1'b0;
                            out_y     <= 1'b0;
                            out_first <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            cnt       <= '0;
                            state     <= FILL;
                        end else begin
                            out_x     <= core_x;
                            out_y     <= core_y;
                            out_first <= 1'b0;
                            out_last  <= (cnt == LAST_PAIR);
                            cnt       <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fec_conv_encoder.sv
// tb_fec_conv_encoder
// Self-checking bench: a behavioural encoder model fills a scoreboard queue
// when a block has been fed; pairs are popped and compared as the DUT hands
// them over. A table of fixed pair values is checked at the end.
module tb_fec_conv_encoder;

    localparam int BL = 96;
`ifdef CONV_ENC_TAILBITE_EN
    localparam int NP = BL;
`else
    localparam int NP = BL + 6;
`endif

    logic clk;
    logic reset;
    logic in_valid;
    logic in_bit;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic out_x;
    logic out_y;
    logic out_first;
    logic out_last;

    fec_conv_encoder #(.BLOCK_LEN(BL)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_first (out_first),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] xy;
        logic       first;
        logic       last;
    } pair_t;

    typedef struct {
        int         blk;
        int         pair;
        logic [1:0] xy;
    } tv_t;

    pair_t      sbq[$];
    tv_t        tv[$];
    logic [1:0] got [6][NP];
    int         got_n [6];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference encoder written directly from the X/Y equations.
    task automatic model_push(input logic [BL-1:0] b);
        logic [6:1] s;
        logic       u;
        pair_t      e;
`ifdef CONV_ENC_TAILBITE_EN
        for (int k = 1; k <= 6; k++) s[k] = b[BL-k];
`else
        s = '0;
`endif
        for (int i = 0; i < NP; i++) begin
            u       = (i < BL) ? b[i] : 1'b0;
            e.xy    = {u ^ s[1] ^ s[2] ^ s[3] ^ s[6], u ^ s[2] ^ s[3] ^ s[5] ^ s[6]};
            e.first = (i == 0);
            e.last  = (i == NP - 1);
            sbq.push_back(e);
            s = {s[5:1], u};
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge accepting the last bit.
    task automatic feed(input logic [BL-1:0] b, input int gap_pct);
        int   i;
        int   guard;
        logic rdy;
        i     = 0;
        guard = 0;
        chk("in_ready_fill", in_ready, 1);
        while (i < BL && guard < BL * 10) begin
            guard++;
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_bit   = in_valid ? b[i] : 1'($urandom_range(0, 1));
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (in_valid && rdy) i++;
        end
        in_valid = 1'b0;
        if (i < BL) chk("feed_timeout", i, BL);
        model_push(b);
    endtask

    // Called in the PRELOAD cycle. abort_at >= 0 resets the DUT when that pair is shown.
    task automatic drain(input int blk, input int stall_pct, input int abort_at);
        int         k;
        int         cyc;
        bit         done;
        bit         prev_stall;
        logic [3:0] prev;
        pair_t      e;
        k          = 0;
        cyc        = 0;
        done       = 1'b0;
        prev_stall = 1'b0;
        prev       = '0;
        chk("preload_out_valid", out_valid, 0);
        chk("preload_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk);
        #1;
        chk("latency_out_valid", out_valid, 1);
        while (!done && cyc < NP * 20) begin
            cyc++;
            chk("encode_out_valid", out_valid, 1);
            chk("encode_in_ready", in_ready, 0);
            if (prev_stall) chk("hold", {out_x, out_y, out_first, out_last}, prev);
            if (abort_at >= 0 && k == abort_at) begin
                reset    = 1'b1;
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_in_ready", in_ready, 1);
                chk("abort_flags", {out_first, out_last, out_x, out_y}, 0);
                reset = 1'b0;
                sbq.delete();
                got_n[blk] = k;
                return;
            end
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            if (out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                    done = 1'b1;
                end else begin
                    e = sbq.pop_front();
                    chk("pair_xy", {out_x, out_y}, e.xy);
                    chk("pair_first", out_first, e.first);
                    chk("pair_last", out_last, e.last);
                    got[blk][k] = {out_x, out_y};
                    k++;
                    done = e.last;
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev       = {out_x, out_y, out_first, out_last};
            end
            in_valid = 1'($urandom_range(0, 1));
            in_bit   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("drain_timeout", cyc, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        got_n[blk] = k;
    endtask

    initial begin
        logic [BL-1:0] b;

        // Expected pair values for block 0 (zeros), 1 (b[0]=1), 2 (b[95]=1).
        tv.push_back('{0, 0, 2'b00});
        tv.push_back('{0, NP - 1, 2'b00});
        tv.push_back('{1, 0, 2'b11});
        tv.push_back('{1, 1, 2'b10});
        tv.push_back('{1, 2, 2'b11});
        tv.push_back('{1, 3, 2'b11});
        tv.push_back('{1, 4, 2'b00});
        tv.push_back('{1, 5, 2'b01});
        tv.push_back('{1, 6, 2'b11});
        tv.push_back('{1, 7, 2'b00});
        tv.push_back('{1, NP - 1, 2'b00});
`ifdef CONV_ENC_TAILBITE_EN
        tv.push_back('{2, 0, 2'b10});
        tv.push_back('{2, 1, 2'b11});
        tv.push_back('{2, 2, 2'b11});
        tv.push_back('{2, 3, 2'b00});
        tv.push_back('{2, 4, 2'b01});
        tv.push_back('{2, 5, 2'b11});
        tv.push_back('{2, 6, 2'b00});
        tv.push_back('{2, 94, 2'b00});
        tv.push_back('{2, 95, 2'b11});
`else
        tv.push_back('{2, 0, 2'b00});
        tv.push_back('{2, 94, 2'b00});
        tv.push_back('{2, 95, 2'b11});
        tv.push_back('{2, 96, 2'b10});
        tv.push_back('{2, 97, 2'b11});
        tv.push_back('{2, 98, 2'b11});
        tv.push_back('{2, 99, 2'b00});
        tv.push_back('{2, 100, 2'b01});
        tv.push_back('{2, 101, 2'b11});
`endif

        for (int i = 0; i < 6; i++) got_n[i] = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_outputs", {out_valid, out_x, out_y, out_first, out_last}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        b = '0;
        feed(b, 0);
        drain(0, 0, -1);

        b = '0;
        b[0] = 1'b1;
        feed(b, 0);
        drain(1, 0, -1);

        b = '0;
        b[BL-1] = 1'b1;
        feed(b, 0);
        drain(2, 0, -1);

        for (int i = 0; i < BL; i++) b[i] = 1'($urandom_range(0, 1));
        feed(b, 25);
        drain(3, 40, -1);

        for (int i = 0; i < BL; i++) b[i] = 1'($urandom_range(0, 1));
        feed(b, 0);
        drain(4, 30, 40);

        b = '0;
        feed(b, 0);
        drain(5, 0, -1);

        for (int i = 0; i < 3; i++) chk("pairs_per_block", got_n[i], NP);
        chk("pairs_after_abort", got_n[5], NP);
        foreach (tv[i]) begin
            chk($sformatf("table_b%0d_p%0d", tv[i].blk, tv[i].pair),
                got[tv[i].blk][tv[i].pair], tv[i].xy);
        end
        for (int i = 0; i < NP; i++) begin
            if (got[5][i] !== 2'b00) chk("post_abort_zero", got[5][i], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
